// File: rtl/sram_controller.sv
// Word-wide load/store responder for an external 16-bit asynchronous SRAM; each word is two half-word cycles.
// Optional range check: define SRAM_ADDR_CHECK_EN to keep out-of-window addresses off the SRAM pins.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 3,
  parameter logic [31:0] ADDR_BASE     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_is_write;
  logic [16:0]      r_word;
  logic [31:0]      r_wdata;
  logic [31:0]      r_read_data;

  logic             w_req;
  logic             w_addr_ok;
  logic             w_last;
  logic             w_xfer;
  logic             w_dq_oe;
  logic [15:0]      w_dq_out;
  logic [16:0]      w_word;

  assign w_req  = MEM_R_EN | MEM_W_EN;
  assign w_word = 17'((address - ADDR_BASE) >> 2);
  assign w_last = (r_cnt == CNT_LAST);
  assign w_xfer = (r_state == S_LOW) || (r_state == S_HIGH);

`ifdef SRAM_ADDR_CHECK_EN
  // Below the base, or past the 2^17-word window, never reaches the SRAM.
  assign w_addr_ok = (address >= ADDR_BASE) && (((address - ADDR_BASE) >> 19) == 32'd0);
`else
  assign w_addr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_addr_ok ? S_LOW : S_DONE;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      // The request is still held here but belongs to the finished op.
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write <= 1'b0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_is_write <= MEM_W_EN;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_req) begin
      r_word  <= w_word;
      r_wdata <= write_data;
    end
  end

  // Each half is captured at the end of its access window, when the SRAM output has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
    end else if ((r_state == S_IDLE) && w_req && !w_addr_ok && !MEM_W_EN) begin
      r_read_data <= '0;
    end else if ((r_state == S_LOW) && w_last && !r_is_write) begin
      r_read_data[15:0] <= SRAM_DQ;
    end else if ((r_state == S_HIGH) && w_last && !r_is_write) begin
      r_read_data[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    if (r_state == S_LOW) begin
      SRAM_ADDR = {r_word, 1'b0};
    end else if (r_state == S_HIGH) begin
      SRAM_ADDR = {r_word, 1'b1};
    end
  end

  // Strobe drops in the final cycle of each half so it rises before the address moves.
  assign SRAM_WE_N = !(r_is_write && w_xfer && !w_last);
  assign w_dq_oe   = r_is_write && w_xfer;
  assign w_dq_out  = (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;

  assign read_data = r_read_data;
  assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
